// File: rtl/codec_stream_bridge.sv
// Byte-stream adapter for the arithmetic codec: packs host bytes LSB-first into codec
// words, zero-pads past end-of-stream, and unpacks variable-length results into a byte FIFO.
module codec_stream_bridge #(
  parameter int BYTES     = 4,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   inByte,
  input  logic                         inValid,
  input  logic                         inLast,
  output logic                         inReady,
  input  logic                         newBitsRequested,
  output logic                         newBitsProvided,
  output logic [8*BYTES-1:0]           inputBits,
  input  logic                         resultReady,
  input  logic [$clog2(BYTES+1)-1:0]   validOutputBytes,
  input  logic [8*BYTES-1:0]           out,
  output logic                         readSuccess,
  output logic [7:0]                   outByte,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [15:0]                  padWords,
  output logic                         lenErr
);

  localparam int WW  = 8 * BYTES;
  localparam int VW  = $clog2(BYTES + 1);
  localparam int PCW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  // Handshakes: host bytes transfer on inValid && inReady, host pops on outValid && outReady.
  // Codec side is level request / one-cycle pulse reply; each FSM re-arms only after the
  // codec drops its level (newBitsRequested / resultReady sampled low).
  typedef enum logic { REQ_IDLE, REQ_ACK } req_state_t;
  typedef enum logic { OUT_IDLE, OUT_ACK } out_state_t;

  req_state_t reqState;
  out_state_t outState;

  // ---------------- packer and word FIFO ----------------
  logic [PCW-1:0] packCount;
  logic [WW-1:0]  packWord;
  logic [WW-1:0]  laneWord;
  logic           eosSeen;
  logic [WW-1:0]  wordMem [IN_DEPTH];
  logic [IAW-1:0] wordWr;
  logic [IAW-1:0] wordRd;
  logic [ICW-1:0] wordCount;
  logic           wordFull;
  logic           accept;
  logic           lastLane;
  logic           wordPush;
  logic           wordPop;

  always_comb begin
    laneWord = packWord;
    for (int k = 0; k < BYTES; k++) begin
      if (packCount == PCW'(k)) laneWord[8*k +: 8] = inByte;
    end
  end

  assign wordFull = (wordCount == ICW'(IN_DEPTH));
  assign inReady  = !rst && !eosSeen && !wordFull;
  assign accept   = inValid && inReady;
  assign lastLane = (packCount == PCW'(BYTES - 1));
  assign wordPush = accept && (lastLane || inLast);
  assign wordPop  = (reqState == REQ_IDLE) && newBitsRequested && (wordCount != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      packCount <= '0;
      packWord  <= '0;
      eosSeen   <= 1'b0;
      wordWr    <= '0;
      wordRd    <= '0;
      wordCount <= '0;
    end else begin
      if (accept) begin
        if (lastLane || inLast) begin
          packCount <= '0;
          packWord  <= '0;
        end else begin
          packCount <= packCount + 1'b1;
          packWord  <= laneWord;
        end
        if (inLast) eosSeen <= 1'b1;
      end
      if (wordPush) wordWr <= wordWr + 1'b1;
      if (wordPop)  wordRd <= wordRd + 1'b1;
      wordCount <= wordCount + ICW'(wordPush) - ICW'(wordPop);
    end
  end

  always_ff @(posedge clk) begin
    if (wordPush) wordMem[wordWr] <= laneWord;
  end

  // ---------------- request FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      reqState        <= REQ_IDLE;
      newBitsProvided <= 1'b0;
      inputBits       <= '0;
      padWords        <= '0;
    end else begin
      newBitsProvided <= 1'b0;
      case (reqState)
        REQ_IDLE: begin
          if (newBitsRequested) begin
            if (wordCount != '0) begin
              inputBits       <= wordMem[wordRd];
              newBitsProvided <= 1'b1;
              reqState        <= REQ_ACK;
            end else if (eosSeen && packCount == '0) begin
              // Stream exhausted: keep the codec fed with zero words.
              inputBits       <= '0;
              newBitsProvided <= 1'b1;
              reqState        <= REQ_ACK;
              if (padWords != 16'hFFFF) padWords <= padWords + 16'd1;
            end
          end
        end
        REQ_ACK: begin
          if (!newBitsRequested) reqState <= REQ_IDLE;
        end
        default: reqState <= REQ_IDLE;
      endcase
    end
  end

  // ---------------- result FSM and byte FIFO ----------------
  logic [7:0]     byteMem [OUT_DEPTH];
  logic [OAW-1:0] byteWr;
  logic [OAW-1:0] byteRd;
  logic [OCW-1:0] byteCount;
  logic [OCW-1:0] byteFree;
  logic [OCW-1:0] nBytes;
  logic           overLen;
  logic           resultTake;
  logic           bytePop;

  assign overLen    = (validOutputBytes > VW'(BYTES));
  assign nBytes     = overLen ? OCW'(BYTES) : OCW'(validOutputBytes);
  // Free space ignores a same-cycle pop so acceptance never depends on outReady.
  assign byteFree   = OCW'(OUT_DEPTH) - byteCount;
  assign resultTake = (outState == OUT_IDLE) && resultReady && (byteFree >= nBytes);
  assign outValid   = (byteCount != '0);
  assign bytePop    = outValid && outReady;
  assign outByte    = outValid ? byteMem[byteRd] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      outState    <= OUT_IDLE;
      readSuccess <= 1'b0;
      lenErr      <= 1'b0;
      byteWr      <= '0;
      byteRd      <= '0;
      byteCount   <= '0;
    end else begin
      readSuccess <= 1'b0;
      case (outState)
        OUT_IDLE: begin
          if (resultReady) begin
            if (overLen) lenErr <= 1'b1;
            if (resultTake) begin
              readSuccess <= 1'b1;
              outState    <= OUT_ACK;
            end
          end
        end
        OUT_ACK: begin
          if (!resultReady) outState <= OUT_IDLE;
        end
        default: outState <= OUT_IDLE;
      endcase
      if (resultTake) byteWr <= byteWr + OAW'(nBytes);
      if (bytePop)    byteRd <= byteRd + 1'b1;
      byteCount <= byteCount + (resultTake ? nBytes : '0) - OCW'(bytePop);
    end
  end

  always_ff @(posedge clk) begin
    if (resultTake) begin
      for (int k = 0; k < BYTES; k++) begin
        if (OCW'(k) < nBytes) byteMem[byteWr + OAW'(k)] <= out[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_codec_stream_bridge.sv
// Bench for codec_stream_bridge: directed and randomized traffic on both codec sides,
// checked against a byte/word queue model of the packing and unpacking rules.
module tb_codec_stream_bridge;

  localparam int BYTES     = 4;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 16;
  localparam int WW        = 8 * BYTES;

  logic          clk;
  logic          rst;
  logic [7:0]    inByte;
  logic          inValid;
  logic          inLast;
  logic          inReady;
  logic          newBitsRequested;
  logic          newBitsProvided;
  logic [WW-1:0] inputBits;
  logic          resultReady;
  logic [2:0]    validOutputBytes;
  logic [WW-1:0] out;
  logic          readSuccess;
  logic [7:0]    outByte;
  logic          outValid;
  logic          outReady;
  logic [15:0]   padWords;
  logic          lenErr;

  codec_stream_bridge #(.BYTES(BYTES), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst), .inByte(inByte), .inValid(inValid), .inLast(inLast),
    .inReady(inReady), .newBitsRequested(newBitsRequested), .newBitsProvided(newBitsProvided),
    .inputBits(inputBits), .resultReady(resultReady), .validOutputBytes(validOutputBytes),
    .out(out), .readSuccess(readSuccess), .outByte(outByte), .outValid(outValid),
    .outReady(outReady), .padWords(padWords), .lenErr(lenErr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [WW-1:0] exp_word_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    got_q[$];
  logic [7:0]    pend_q[$];
  bit            model_eos;
  int            model_pad;
  bit            rand_ready;

  always @(negedge clk) begin
    if (!rst && outValid && outReady) got_q.push_back(outByte);
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) outReady = ($urandom_range(0, 1) == 1);
  endtask

  task automatic model_reset();
    exp_word_q.delete();
    exp_q.delete();
    got_q.delete();
    pend_q.delete();
    model_eos = 0;
    model_pad = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    logic [WW-1:0] w;
    pend_q.push_back(b);
    if (pend_q.size() == BYTES || last) begin
      w = '0;
      foreach (pend_q[i]) w[8*i +: 8] = pend_q[i];
      exp_word_q.push_back(w);
      pend_q.delete();
    end
    if (last) model_eos = 1;
  endtask

  task automatic model_word(output logic [WW-1:0] w);
    if (exp_word_q.size() != 0) w = exp_word_q.pop_front();
    else begin
      w = '0;
      model_pad++;
    end
  endtask

  // driver: one host byte, waits (bounded) for inReady
  task automatic send_byte(input logic [7:0] b, input bit last);
    bit ok = 0;
    inByte = b; inLast = last; inValid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (inReady) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    inValid = 1'b0; inLast = 1'b0;
    if (ok) model_byte(b, last);
    else check("byte_accept_timeout", 0, 1);
  endtask

  // driver: one codec word request
  task automatic do_request(input string tag);
    bit got = 0;
    logic [WW-1:0] w;
    newBitsRequested = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (newBitsProvided) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      model_word(w);
      check(tag, inputBits, w);
    end else check({tag, "_timeout"}, 0, 1);
    newBitsRequested = 1'b0;
    tick();
    check({tag, "_pulse_len"}, newBitsProvided, 0);
  endtask

  task automatic model_result(input int vob, input logic [WW-1:0] d);
    int n = (vob > BYTES) ? BYTES : vob;
    for (int k = 0; k < n; k++) exp_q.push_back(d[8*k +: 8]);
  endtask

  // driver: one codec result
  task automatic send_result(input string tag, input int vob, input logic [WW-1:0] d);
    bit got = 0;
    resultReady = 1'b1; validOutputBytes = 3'(vob); out = d;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (readSuccess) begin
        got = 1;
        break;
      end
    end
    if (got) model_result(vob, d);
    else check({tag, "_timeout"}, 0, 1);
    resultReady = 1'b0;
    tick();
    check({tag, "_pulse_len"}, readSuccess, 0);
  endtask

  task automatic compare_bytes(input string tag);
    outReady = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) tick();
    tick();
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  initial begin
    int accepted;
    bit stalled;
    logic [WW-1:0] w;
    logic [WW-1:0] d;
    int vob;

    rst = 1'b1; inByte = '0; inValid = 0; inLast = 0; newBitsRequested = 0;
    resultReady = 0; validOutputBytes = '0; out = '0; outReady = 0; rand_ready = 0;
    model_reset();

    // reset state
    tick(); tick();
    check("rst_inReady", inReady, 0);
    check("rst_newBitsProvided", newBitsProvided, 0);
    check("rst_inputBits", inputBits, 0);
    check("rst_readSuccess", readSuccess, 0);
    check("rst_outValid", outValid, 0);
    check("rst_outByte", outByte, 0);
    check("rst_padWords", padWords, 0);
    check("rst_lenErr", lenErr, 0);
    rst = 1'b0;
    #1;
    check("post_rst_inReady", inReady, 1);

    // eight bytes, two words
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
    do_request("word_a");
    do_request("word_b");
    check("pad_zero", padWords, 0);

    // end of stream with partial word and zero padding
    for (int i = 0; i < 5; i++) send_byte(8'h0A + 8'(i), i == 4);
    check("inReady_after_last", inReady, 0);
    do_request("eos_full");
    do_request("eos_partial");
    do_request("eos_pad");
    check("pad_one", padWords, 16'(model_pad));

    // fill the word FIFO with random bytes, nothing requested
    pulse_reset();
    accepted = 0;
    inValid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      inByte = 8'($urandom);
      if (!inReady) break;
      tick();
      model_byte(inByte, 0);
      accepted++;
    end
    inValid = 1'b0;
    check("fill_count", accepted, IN_DEPTH * BYTES);
    check("fill_inReady", inReady, 0);
    newBitsRequested = 1'b1;
    tick();
    check("fill_pulse", newBitsProvided, 1);
    model_word(w);
    check("fill_word", inputBits, w);
    check("fill_inReady_freed", inReady, 1);
    newBitsRequested = 1'b0;
    tick();
    for (int i = 0; i < IN_DEPTH - 1; i++) do_request("fill_drain");

    // randomized interleaving of bytes and requests
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom), 0);
      if (exp_word_q.size() >= 2 || $urandom_range(0, 3) == 0) begin
        if (exp_word_q.size() != 0) do_request("rand_word");
      end
    end
    while (exp_word_q.size() != 0) do_request("rand_word_tail");

    // variable-length results
    outReady = 1'b1;
    send_result("res_3", 3, 32'h44434241);
    send_result("res_0", 0, 32'h44434241);
    send_result("res_4", 4, 32'h44434241);
    compare_bytes("res_bytes");
    check("lenErr_clear", lenErr, 0);

    // byte FIFO back-pressure
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) send_result("bp_fill", 4, $urandom);
    d = $urandom;
    resultReady = 1'b1; validOutputBytes = 3'd4; out = d;
    stalled = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (readSuccess) stalled = 0;
    end
    check("bp_stall", stalled, 1);
    outReady = 1'b1;
    stalled = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (readSuccess) begin
        stalled = 0;
        break;
      end
    end
    check("bp_resume", stalled, 0);
    model_result(4, d);
    resultReady = 1'b0;
    tick();
    compare_bytes("bp_bytes");

    // over-length result
    d = $urandom;
    send_result("res_5", 5, d);
    check("lenErr_set", lenErr, 1);
    compare_bytes("res5_bytes");

    // randomized results with random host back-pressure
    rand_ready = 1;
    for (int i = 0; i < 10; i++) begin
      vob = $urandom_range(0, 4);
      send_result("rand_res", vob, $urandom);
    end
    rand_ready = 0;
    compare_bytes("rand_res_bytes");

    // reset with buffered words, buffered bytes and REQ_ACK active
    outReady = 1'b0;
    send_result("pre_rst_res", 4, $urandom);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    newBitsRequested = 1'b1;
    tick();
    check("pre_rst_pulse", newBitsProvided, 1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_newBitsProvided", newBitsProvided, 0);
    check("mid_rst_inputBits", inputBits, 0);
    check("mid_rst_outValid", outValid, 0);
    check("mid_rst_outByte", outByte, 0);
    check("mid_rst_lenErr", lenErr, 0);
    check("mid_rst_inReady", inReady, 0);
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_post_inReady", inReady, 1);
    stalled = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (newBitsProvided) stalled = 1;
    end
    check("mid_post_no_word", stalled, 0);
    check("mid_post_outValid", outValid, 0);
    newBitsRequested = 1'b0;
    tick();
    for (int i = 0; i < BYTES; i++) send_byte(8'($urandom), 0);
    do_request("post_rst_word");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
